// File: rtl/fma16_sched_if.sv
// fma16_sched_if -- bundle of every signal between the fma16 scheduler and
// its surroundings: two requester channels, the shared fma16 datapath and
// the response channel.
//
//   req0_* / req1_* : valid/ready handshake plus opcode, x/y/z operands and
//                     rounding mode for each of the two requesters
//   fma_*           : registered operands and controls to the shared
//                     datapath; fma_result is its combinational result
//   rsp_*           : valid/ready response channel (owner id, result,
//                     illegal-opcode flag)
//   busy            : scheduler is not idle
//
// slave  : the scheduler side (fma16_sched)
// master : the environment side (requesters, datapath, response consumer)
interface fma16_sched_if;
   logic        req0_valid;
   logic        req0_ready;
   logic [2:0]  req0_op;
   logic [15:0] req0_x;
   logic [15:0] req0_y;
   logic [15:0] req0_z;
   logic [1:0]  req0_rm;

   logic        req1_valid;
   logic        req1_ready;
   logic [2:0]  req1_op;
   logic [15:0] req1_x;
   logic [15:0] req1_y;
   logic [15:0] req1_z;
   logic [1:0]  req1_rm;

   logic [15:0] fma_x;
   logic [15:0] fma_y;
   logic [15:0] fma_z;
   logic        fma_mul;
   logic        fma_add;
   logic        fma_negr;
   logic        fma_negz;
   logic [1:0]  fma_roundmode;
   logic [15:0] fma_result;

   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_id;
   logic [15:0] rsp_result;
   logic        rsp_illegal;
   logic        busy;

   modport slave (
      input  req0_valid, req0_op, req0_x, req0_y, req0_z, req0_rm,
      input  req1_valid, req1_op, req1_x, req1_y, req1_z, req1_rm,
      input  fma_result, rsp_ready,
      output req0_ready, req1_ready,
      output fma_x, fma_y, fma_z, fma_mul, fma_add, fma_negr, fma_negz, fma_roundmode,
      output rsp_valid, rsp_id, rsp_result, rsp_illegal, busy
   );

   modport master (
      output req0_valid, req0_op, req0_x, req0_y, req0_z, req0_rm,
      output req1_valid, req1_op, req1_x, req1_y, req1_z, req1_rm,
      output fma_result, rsp_ready,
      input  req0_ready, req1_ready,
      input  fma_x, fma_y, fma_z, fma_mul, fma_add, fma_negr, fma_negz, fma_roundmode,
      input  rsp_valid, rsp_id, rsp_result, rsp_illegal, busy
   );
endinterface

// File: rtl/fma16_sched.sv
// fma16_sched -- round-robin scheduler sharing one fma16 datapath between two
// requesters, one operation in flight at a time.
//
// Ports:
//   clk   : single clock, rising edge
//   reset : asynchronous, active-high; clears all state
//   bus   : fma16_sched_if.slave (requester handshakes, datapath operands
//           and controls, response channel, busy)
//
// Parameter LAT (1..15): clock edges from the accepting edge to the edge that
// samples fma_result into rsp_result.
module fma16_sched #(
   parameter int LAT = 2
) (
   input logic          clk,
   input logic          reset,
   fma16_sched_if.slave bus
);

   localparam logic [3:0]  CNT_LOAD = 4'(LAT - 1);
   localparam logic [15:0] QNAN     = 16'h7E00;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic        ptr;
   logic [3:0]  cnt;

   logic        grant0;
   logic        grant1;
   logic        acc;
   logic        acc_id;
   logic        acc_illegal;
   logic [2:0]  acc_op;
   logic [15:0] acc_x;
   logic [15:0] acc_y;
   logic [15:0] acc_z;
   logic [1:0]  acc_rm;

   // Opcode to {mul, add, negr, negz}; 111 never reaches the datapath.
   function automatic logic [3:0] decode_op(input logic [2:0] op);
      logic [3:0] c;
      case (op)
         3'b000:  c = 4'b0100;
         3'b001:  c = 4'b0101;
         3'b010:  c = 4'b1000;
         3'b011:  c = 4'b1100;
         3'b100:  c = 4'b1101;
         3'b101:  c = 4'b1110;
         3'b110:  c = 4'b1111;
         default: c = 4'b0000;
      endcase
      return c;
   endfunction

   // Round-robin grant: contention goes to ptr, a lone request always wins.
   always_comb begin
      grant0 = bus.req0_valid & (~bus.req1_valid | ~ptr);
      grant1 = bus.req1_valid & (~bus.req0_valid | ptr);
   end

   // Operation of whichever requester holds the grant.
   always_comb begin
      acc_id = grant1;
      if (grant1) begin
         acc_op = bus.req1_op;
         acc_x  = bus.req1_x;
         acc_y  = bus.req1_y;
         acc_z  = bus.req1_z;
         acc_rm = bus.req1_rm;
      end else begin
         acc_op = bus.req0_op;
         acc_x  = bus.req0_x;
         acc_y  = bus.req0_y;
         acc_z  = bus.req0_z;
         acc_rm = bus.req0_rm;
      end
      acc_illegal = (acc_op == 3'b111);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Ready only in IDLE and never while reset is held; ready implies valid,
   // so any grant in IDLE is an accept at the coming edge.
   always_comb begin
      state_nxt      = state;
      bus.req0_ready = 1'b0;
      bus.req1_ready = 1'b0;
      bus.rsp_valid  = 1'b0;
      bus.busy       = 1'b1;
      acc            = 1'b0;
      case (state)
         IDLE: begin
            bus.busy       = 1'b0;
            bus.req0_ready = grant0 & ~reset;
            bus.req1_ready = grant1 & ~reset;
            acc            = (grant0 | grant1) & ~reset;
            if (acc) state_nxt = BUSY;
         end
         BUSY: begin
            if (cnt == 4'd0) state_nxt = RESP;
         end
         RESP: begin
            bus.rsp_valid = 1'b1;
            if (bus.rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Issue stage: operands go out on accept. An illegal opcode parks its
   // canned response immediately and spends one BUSY cycle with cnt=0, which
   // gives it the same one-edge response latency as LAT=1; rsp_illegal then
   // suppresses the fma_result capture.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr               <= 1'b0;
         cnt               <= 4'd0;
         bus.fma_x         <= 16'h0000;
         bus.fma_y         <= 16'h0000;
         bus.fma_z         <= 16'h0000;
         bus.fma_mul       <= 1'b0;
         bus.fma_add       <= 1'b0;
         bus.fma_negr      <= 1'b0;
         bus.fma_negz      <= 1'b0;
         bus.fma_roundmode <= 2'b00;
         bus.rsp_id        <= 1'b0;
         bus.rsp_result    <= 16'h0000;
         bus.rsp_illegal   <= 1'b0;
      end else begin
         if (acc) begin
            ptr        <= ~acc_id;
            bus.rsp_id <= acc_id;
            if (acc_illegal) begin
               bus.rsp_result  <= QNAN;
               bus.rsp_illegal <= 1'b1;
               cnt             <= 4'd0;
            end else begin
               bus.fma_x         <= acc_x;
               bus.fma_y         <= acc_y;
               bus.fma_z         <= acc_z;
               {bus.fma_mul, bus.fma_add, bus.fma_negr, bus.fma_negz} <= decode_op(acc_op);
               bus.fma_roundmode <= acc_rm;
               bus.rsp_illegal   <= 1'b0;
               cnt               <= CNT_LOAD;
            end
         end
         // Result stage: sample the datapath when the countdown expires.
         if (state == BUSY) begin
            if (cnt == 4'd0) begin
               if (!bus.rsp_illegal) bus.rsp_result <= bus.fma_result;
            end else begin
               cnt <= cnt - 4'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_fma16_sched.sv
// tb_fma16_sched -- three schedulers (LAT = 2, 1, 4) each driving its own
// stand-in datapath. Tasks drive requests and check grants, issued operands,
// response latency and response contents against a transaction-level model
// (round-robin pointer, last-issued operand set, opcode table).
module tb_fma16_sched;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   logic        rv  [3][2];
   logic [2:0]  rop [3][2];
   logic [15:0] rx  [3][2];
   logic [15:0] ry  [3][2];
   logic [15:0] rz  [3][2];
   logic [1:0]  rrm [3][2];
   logic        rsp_rdy [3];

   wire         rrdy [3][2];
   wire  [15:0] fx [3];
   wire  [15:0] fy [3];
   wire  [15:0] fz [3];
   wire  [3:0]  fc [3];
   wire  [1:0]  frm [3];
   wire  [15:0] rres [3];
   wire         rvld [3];
   wire         rid [3];
   wire         rill [3];
   wire         bsy [3];

   logic        ptr_m [3];
   logic [53:0] last_m [3];

   always #5 clk = ~clk;

   // Stand-in datapath: 1.0 * y returns y exactly, anything else is a hash
   // that depends on every operand and control bit.
   function automatic logic [15:0] dp(input logic [15:0] x, input logic [15:0] y,
                                      input logic [15:0] z, input logic [3:0] c,
                                      input logic [1:0] rm);
      logic [15:0] h;
      if (c == 4'b1000 && x == 16'h3C00) return y;
      h = (x + {y[7:0], y[15:8]}) ^ (z * 16'd5) ^ {c, rm, 10'h155};
      return h;
   endfunction

   function automatic logic [3:0] exp_ctrl(input logic [2:0] op);
      case (op)
         3'b000:  return 4'b0100;
         3'b001:  return 4'b0101;
         3'b010:  return 4'b1000;
         3'b011:  return 4'b1100;
         3'b100:  return 4'b1101;
         3'b101:  return 4'b1110;
         3'b110:  return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic int lat_of(input int d);
      return (d == 0) ? 2 : (d == 1) ? 1 : 4;
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int L = (g == 0) ? 2 : (g == 1) ? 1 : 4;
      fma16_sched_if bus ();
      assign bus.req0_valid = rv[g][0];
      assign bus.req0_op    = rop[g][0];
      assign bus.req0_x     = rx[g][0];
      assign bus.req0_y     = ry[g][0];
      assign bus.req0_z     = rz[g][0];
      assign bus.req0_rm    = rrm[g][0];
      assign bus.req1_valid = rv[g][1];
      assign bus.req1_op    = rop[g][1];
      assign bus.req1_x     = rx[g][1];
      assign bus.req1_y     = ry[g][1];
      assign bus.req1_z     = rz[g][1];
      assign bus.req1_rm    = rrm[g][1];
      assign bus.rsp_ready  = rsp_rdy[g];
      assign bus.fma_result = dp(bus.fma_x, bus.fma_y, bus.fma_z,
                                 {bus.fma_mul, bus.fma_add, bus.fma_negr, bus.fma_negz},
                                 bus.fma_roundmode);
      assign rrdy[g][0] = bus.req0_ready;
      assign rrdy[g][1] = bus.req1_ready;
      assign fx[g]      = bus.fma_x;
      assign fy[g]      = bus.fma_y;
      assign fz[g]      = bus.fma_z;
      assign fc[g]      = {bus.fma_mul, bus.fma_add, bus.fma_negr, bus.fma_negz};
      assign frm[g]     = bus.fma_roundmode;
      assign rres[g]    = bus.rsp_result;
      assign rvld[g]    = bus.rsp_valid;
      assign rid[g]     = bus.rsp_id;
      assign rill[g]    = bus.rsp_illegal;
      assign bsy[g]     = bus.busy;

      fma16_sched #(.LAT(L)) dut (
         .clk   (clk),
         .reset (reset),
         .bus   (bus)
      );
   end

   task automatic clear_model();
      for (int d = 0; d < 3; d++) begin
         ptr_m[d]  = 1'b0;
         last_m[d] = '0;
      end
   endtask

   task automatic issue(input int d, input int n, input logic [2:0] op,
                        input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] z, input logic [1:0] rm);
      rv[d][n]  = 1'b1;
      rop[d][n] = op;
      rx[d][n]  = x;
      ry[d][n]  = y;
      rz[d][n]  = z;
      rrm[d][n] = rm;
   endtask

   task automatic issue_rand(input int d, input int n, input int max_op);
      issue(d, n, 3'($urandom_range(0, max_op)), 16'($urandom), 16'($urandom),
            16'($urandom), 2'($urandom_range(0, 3)));
   endtask

   // One complete transaction on DUT d from the currently offered requests.
   // Called at a falling edge; returns at the falling edge after the
   // response handshake. hold = cycles rsp_ready stays low in RESP.
   task automatic do_txn(input int d, input int hold);
      logic        g;
      logic        ill;
      logic [2:0]  op;
      logic [3:0]  c;
      logic [15:0] eres;
      logic [53:0] efma;
      logic [53:0] ofma;
      int          lat;
      int          elat;
      #1;
      g = (rv[d][0] && rv[d][1]) ? ptr_m[d] : rv[d][1];
      total++;
      if ({rrdy[d][0], rrdy[d][1]} !== {~g, g}) begin
         bad++;
         $display("FAIL grant dut=%0d got ready0/1=%b%b want=%b%b", d, rrdy[d][0], rrdy[d][1], ~g, g);
      end
      op  = rop[d][g];
      ill = (op == 3'b111);
      c   = exp_ctrl(op);
      if (ill) begin
         efma = last_m[d];
         eres = 16'h7E00;
         elat = 1;
      end else begin
         efma = {rx[d][g], ry[d][g], rz[d][g], c, rrm[d][g]};
         eres = dp(rx[d][g], ry[d][g], rz[d][g], c, rrm[d][g]);
         elat = lat_of(d);
      end
      @(posedge clk);
      ptr_m[d]  = ~g;
      last_m[d] = efma;
      @(negedge clk);
      rv[d][g] = 1'b0;
      ofma = {fx[d], fy[d], fz[d], fc[d], frm[d]};
      total++;
      if ({ofma, bsy[d]} !== {efma, 1'b1}) begin
         bad++;
         $display("FAIL issue dut=%0d op=%0d got fma/busy=%h/%b want=%h/1", d, op, ofma, bsy[d], efma);
      end
      lat = 0;
      while (rvld[d] !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      total++;
      if (lat != elat) begin
         bad++;
         $display("FAIL latency dut=%0d op=%0d got=%0d want=%0d", d, op, lat, elat);
      end
      total++;
      if ({rid[d], rill[d], rres[d]} !== {g, ill, eres}) begin
         bad++;
         $display("FAIL response dut=%0d got id/ill/res=%b/%b/%h want=%b/%b/%h",
                  d, rid[d], rill[d], rres[d], g, ill, eres);
      end
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         total++;
         if ({rvld[d], rid[d], rill[d], rres[d], rrdy[d][0], rrdy[d][1]} !== {1'b1, g, ill, eres, 2'b00}) begin
            bad++;
            $display("FAIL hold dut=%0d cycle=%0d got vld/id/ill/res/rdy=%b/%b/%b/%h/%b%b want=1/%b/%b/%h/00",
                     d, i, rvld[d], rid[d], rill[d], rres[d], rrdy[d][0], rrdy[d][1], g, ill, eres);
         end
      end
      rsp_rdy[d] = 1'b1;
      @(negedge clk);
      rsp_rdy[d] = 1'b0;
      total++;
      if ({rvld[d], bsy[d]} !== 2'b00) begin
         bad++;
         $display("FAIL release dut=%0d got vld/busy=%b%b want=00", d, rvld[d], bsy[d]);
      end
   endtask

   task automatic test_reset();
      logic [75:0] obs;
      reset = 1'b1;
      for (int d = 0; d < 3; d++)
         for (int n = 0; n < 2; n++) issue(d, n, 3'b010, 16'h1234, 16'h5678, 16'h9ABC, 2'b10);
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         obs = {rrdy[d][0], rrdy[d][1], rvld[d], bsy[d], rid[d], rill[d], rres[d],
                fx[d], fy[d], fz[d], fc[d], frm[d]};
         total++;
         if (obs !== 76'd0) begin
            bad++;
            $display("FAIL reset_state dut=%0d got=%h want=0", d, obs);
         end
      end
      for (int d = 0; d < 3; d++)
         for (int n = 0; n < 2; n++) rv[d][n] = 1'b0;
      reset = 1'b0;
      clear_model();
   endtask

   task automatic test_fmul();
      issue(0, 0, 3'b010, 16'h3C00, 16'h4000, 16'h0000, 2'b01);
      do_txn(0, 0);
      total++;
      if ({fc[0], rres[0], rid[0]} !== {4'b1000, 16'h4000, 1'b0}) begin
         bad++;
         $display("FAIL fmul_direct got ctrl/res/id=%b/%h/%b want=1000/4000/0", fc[0], rres[0], rid[0]);
      end
   endtask

   task automatic test_arbitration();
      test_reset();
      issue_rand(0, 0, 6);
      issue_rand(0, 1, 6);
      do_txn(0, 0);
      total++;
      if (rid[0] !== 1'b0) begin bad++; $display("FAIL arb_first got id=%b want=0", rid[0]); end
      issue_rand(0, 0, 6);
      do_txn(0, 0);
      total++;
      if (rid[0] !== 1'b1) begin bad++; $display("FAIL arb_second got id=%b want=1", rid[0]); end
      issue_rand(0, 1, 6);
      do_txn(0, 0);
      total++;
      if (rid[0] !== 1'b0) begin bad++; $display("FAIL arb_third got id=%b want=0", rid[0]); end
      do_txn(0, 0);
   endtask

   task automatic test_illegal();
      issue(0, 1, 3'b111, 16'hAAAA, 16'h5555, 16'h0F0F, 2'b11);
      do_txn(0, 0);
      total++;
      if ({rres[0], rill[0], rid[0]} !== {16'h7E00, 1'b1, 1'b1}) begin
         bad++;
         $display("FAIL illegal_direct got res/ill/id=%h/%b/%b want=7e00/1/1", rres[0], rill[0], rid[0]);
      end
   endtask

   task automatic test_back_to_back_hold();
      issue_rand(0, 0, 6);
      issue_rand(0, 1, 6);
      do_txn(0, 5);
      do_txn(0, 0);
   endtask

   task automatic test_reset_mid_busy();
      logic [75:0] obs;
      logic        seen;
      issue(2, 0, 3'b011, 16'h3C00, 16'h4200, 16'h3800, 2'b01);
      @(posedge clk);
      @(negedge clk);
      rv[2][0] = 1'b0;
      total++;
      if (bsy[2] !== 1'b1) begin bad++; $display("FAIL busy_before_reset got=%b want=1", bsy[2]); end
      reset = 1'b1;
      #1;
      obs = {rrdy[2][0], rrdy[2][1], rvld[2], bsy[2], rid[2], rill[2], rres[2],
             fx[2], fy[2], fz[2], fc[2], frm[2]};
      total++;
      if (obs !== 76'd0) begin bad++; $display("FAIL async_reset got=%h want=0", obs); end
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      clear_model();
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         seen = seen | rvld[2];
      end
      total++;
      if (seen !== 1'b0) begin bad++; $display("FAIL rsp_after_reset got=%b want=0", seen); end
      issue_rand(2, 1, 6);
      do_txn(2, 1);
   endtask

   task automatic test_sweep();
      for (int d = 1; d < 3; d++) begin
         for (int op = 0; op < 7; op++) begin
            issue(d, int'($urandom_range(0, 1)), 3'(op), 16'($urandom), 16'($urandom),
                  16'($urandom), 2'($urandom_range(0, 3)));
            do_txn(d, int'($urandom_range(0, 1)));
         end
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 40; it++) begin
         for (int n = 0; n < 2; n++)
            if (!rv[0][n] && $urandom_range(0, 1) == 1) issue_rand(0, n, 7);
         if (!rv[0][0] && !rv[0][1]) issue_rand(0, int'($urandom_range(0, 1)), 7);
         do_txn(0, int'($urandom_range(0, 3)));
      end
      while (rv[0][0] || rv[0][1]) do_txn(0, 0);
   endtask

   initial begin
      reset = 1'b1;
      for (int d = 0; d < 3; d++) begin
         rsp_rdy[d] = 1'b0;
         for (int n = 0; n < 2; n++) begin
            rv[d][n]  = 1'b0;
            rop[d][n] = 3'b000;
            rx[d][n]  = 16'h0000;
            ry[d][n]  = 16'h0000;
            rz[d][n]  = 16'h0000;
            rrm[d][n] = 2'b00;
         end
      end
      clear_model();
      test_reset();
      test_fmul();
      test_arbitration();
      test_illegal();
      test_back_to_back_hold();
      test_reset_mid_busy();
      test_sweep();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1);
   end

endmodule

// File: doc/fma16_sched.md
FMA16_SCHED -- requirements
Module: fma16_sched

Interface
REQ-001 Parameter LAT, default 2: clock edges from operand launch to fma_result sample; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 reqN_valid  input  1  requester N (N=0,1) offers an operation.
REQ-005 reqN_ready  output  1  controller accepts requester N's operation this cycle.
REQ-006 reqN_op  input  3  opcode: 000 fadd, 001 fsub, 010 fmul, 011 fmadd, 100 fmsub, 101 fnmadd, 110 fnmsub, 111 illegal.
REQ-007 reqN_x, reqN_y, reqN_z  input  16 each  half-precision operands.
REQ-008 reqN_rm  input  2  rounding mode: 00 rz, 01 rne, 10 rp, 11 rn.
REQ-009 fma_x, fma_y, fma_z  output  16 each  registered operands to the shared fma16 datapath.
REQ-010 fma_mul, fma_add, fma_negr, fma_negz  output  1 each  registered datapath controls.
REQ-011 fma_roundmode  output  2  registered rounding mode to the datapath.
REQ-012 fma_result  input  16  datapath result, combinational from the fma_* outputs.
REQ-013 rsp_valid  output  1  a response is held.
REQ-014 rsp_ready  input  1  consumer takes the response.
REQ-015 rsp_id  output  1  index of the requester that owns the response.
REQ-016 rsp_result  output  16  captured result.
REQ-017 rsp_illegal  output  1  the response came from opcode 111.
REQ-018 busy  output  1  high whenever state is not IDLE.

Function
REQ-019 FSM states IDLE, BUSY, RESP; one operation in flight at most.
REQ-020 Arbitration is round-robin with pointer ptr: both valid -> grant ptr; one valid -> grant that one.
REQ-021 reqN_ready = (state==IDLE) & grantN, combinational; at most one ready per cycle; ready never depends on rsp_ready.
REQ-022 Accept = reqN_valid & reqN_ready at an edge; on accept, ptr <= the other index and rsp_id <= N.
REQ-023 Legal accept: latch the operands to fma_x/y/z and rm to fma_roundmode, load counter with LAT-1, go to BUSY.
REQ-024 Opcode decode to {mul,add,negr,negz}: 000 0100, 001 0101, 010 1000, 011 1100, 100 1101, 101 1110, 110 1111.
REQ-025 BUSY: counter decrements each edge; at the edge with counter==0, capture fma_result into rsp_result, clear rsp_illegal, go to RESP.
REQ-026 rsp_valid rises exactly LAT edges after the accepting edge; with LAT=1, RESP is entered at the first edge after accept.
REQ-027 Illegal accept (op 111): do not update fma_* outputs; rsp_result <= 16'h7E00; rsp_illegal <= 1; go to RESP at the next edge.
REQ-028 RESP: rsp_valid=1; rsp_result, rsp_id and rsp_illegal remain stable until rsp_valid & rsp_ready, then go to IDLE.
REQ-029 The earliest next accept is in the IDLE cycle after the response handshake; no accept occurs in the same cycle as a response.
REQ-030 fma_* outputs hold their last-issued values when not updated.
REQ-031 A reqN_valid that is not granted is not consumed; the requester holds its request.
REQ-032 ptr is unchanged when no accept occurs.

Reset
REQ-033 On reset: state=IDLE, ptr=0, counter=0, all fma_* outputs 0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_illegal=0, busy=0, reqN_ready=0.
REQ-034 Reset asserted in BUSY or RESP aborts the operation; no response is produced after reset deasserts.

Verification
REQ-035 LAT=2; req0 fmul x=3C00 y=4000 op=010, model datapath result 4000 -> fma_mul=1, fma_add=0; rsp_valid 2 edges after accept; rsp_result=4000; rsp_id=0.
REQ-036 req0 and req1 valid together from reset -> req0 granted first and req1 second; then both again -> req0 (ptr alternates).
REQ-037 op=111 on req1 -> fma_* unchanged; rsp_valid 1 edge after accept; rsp_result=7E00; rsp_illegal=1; rsp_id=1.
REQ-038 rsp_ready held low 5 cycles in RESP -> response stable; req_ready stays 0; after the handshake, IDLE accepts the next request.
REQ-039 reset asserted mid-BUSY -> all outputs at reset values asynchronously; no rsp_valid afterwards without a new accept.
REQ-040 Sweep ops 000..110 with LAT=1 and LAT=4 -> decode per REQ-024 and rsp latency exactly LAT in every case.
